// File: rtl/wormhole_pkg.sv
// Shared types and constants for the wormhole bank.
//   wh_state_t           : teleport FSM state (OPEN / COOLDOWN)
//   TRANSPARENT_ENCODING : RGB value the VGA mux treats as "no pixel"
//   coord_t              : signed 11-bit screen coordinate
package wormhole_pkg;

  typedef enum logic {
    OPEN     = 1'b0,
    COOLDOWN = 1'b1
  } wh_state_t;

  localparam logic [7:0] TRANSPARENT_ENCODING = 8'hFF;

  typedef logic signed [10:0] coord_t;

endpackage

// File: rtl/wormhole_hit.sv
// Combinational bracket test for one square wormhole.
// Ports:
//   pixelX, pixelY       in  : current VGA pixel (signed)
//   topLeftX, topLeftY   in  : active top-left of this hole (signed)
//   hit                  out : pixel lies inside the hole
//   offsetX, offsetY     out : pixel minus top-left, truncated to 11 bits
module wormhole_hit #(
  parameter int OBJECT_WIDTH_X  = 32,
  parameter int OBJECT_HEIGHT_Y = 32
) (
  input  logic signed [10:0] pixelX,
  input  logic signed [10:0] pixelY,
  input  logic signed [10:0] topLeftX,
  input  logic signed [10:0] topLeftY,
  output logic               hit,
  output logic        [10:0] offsetX,
  output logic        [10:0] offsetY
);

  logic signed [11:0] px, py, lx, ly, rx, by;

  // One extra bit keeps right/bottom edges near +1023 and negative
  // positions from wrapping during the compare.
  always_comb begin
    px  = {pixelX[10], pixelX};
    py  = {pixelY[10], pixelY};
    lx  = {topLeftX[10], topLeftX};
    ly  = {topLeftY[10], topLeftY};
    rx  = lx + $signed(12'(OBJECT_WIDTH_X));
    by  = ly + $signed(12'(OBJECT_HEIGHT_Y));
    hit = (px >= lx) && (px < rx) && (py >= ly) && (py < by);
    offsetX = pixelX - topLeftX;
    offsetY = pixelY - topLeftY;
  end

endmodule

// File: rtl/wormhole_bank.sv
// Bank of NUM_HOLES square wormholes, paired as (2k, 2k+1).
// Draws the lowest-index hit hole (1-cycle registered draw path) and
// handles teleport requests: returns the partner's active position and
// then ignores requests for COOLDOWN_FRAMES frame pulses.
// Ports:
//   clk, resetN                       : clock, synchronous active-low reset
//   pixelX, pixelY, startOfFrame      : VGA scan position and frame pulse
//   topLeft{X,Y}_Original / _Cheat    : per-hole normal / cheat positions
//   wormholeCheat                     : cheat select, latched at frame start
//   teleportReq, teleportHole         : collision pulse and hole entered
//   offsetX, offsetY, drawingRequest,
//   RGBout, holeIndex                 : registered draw outputs
//   teleportValid, destX, destY       : one-cycle teleport acknowledge
//   cooldownActive                    : high while in COOLDOWN
// Build option: define WORMHOLE_CHEAT_EN to enable the cheat position path;
// otherwise the cheat inputs are ignored and no latch is built.
module wormhole_bank import wormhole_pkg::*; #(
  parameter int         NUM_HOLES       = 4,
  parameter int         OBJECT_WIDTH_X  = 32,
  parameter int         OBJECT_HEIGHT_Y = 32,
  parameter logic [7:0] OBJECT_COLOR    = 8'h5B,
  parameter logic [7:0] COOLDOWN_COLOR  = 8'h49,
  parameter int         COOLDOWN_FRAMES = 60,
  localparam int        IDX_W           = $clog2(NUM_HOLES)
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic signed [10:0]      pixelX,
  input  logic signed [10:0]      pixelY,
  input  logic                    startOfFrame,
  input  logic signed [10:0]      topLeftX_Original [NUM_HOLES],
  input  logic signed [10:0]      topLeftY_Original [NUM_HOLES],
  input  logic signed [10:0]      topLeftX_Cheat    [NUM_HOLES],
  input  logic signed [10:0]      topLeftY_Cheat    [NUM_HOLES],
  input  logic                    wormholeCheat,
  input  logic                    teleportReq,
  input  logic [IDX_W-1:0]        teleportHole,
  output logic [10:0]             offsetX,
  output logic [10:0]             offsetY,
  output logic                    drawingRequest,
  output logic [7:0]              RGBout,
  output logic [IDX_W-1:0]        holeIndex,
  output logic                    teleportValid,
  output logic signed [10:0]      destX,
  output logic signed [10:0]      destY,
  output logic                    cooldownActive
);

  logic cheat_latched;

`ifdef WORMHOLE_CHEAT_EN
  always_ff @(posedge clk) begin
    if (!resetN)
      cheat_latched <= 1'b0;
    else if (startOfFrame)
      cheat_latched <= wormholeCheat;
  end
`else
  logic unused_cheat;
  assign unused_cheat  = wormholeCheat;
  assign cheat_latched = 1'b0;
`endif

  coord_t act_x [NUM_HOLES];
  coord_t act_y [NUM_HOLES];

  always_comb begin
    for (int unsigned i = 0; i < NUM_HOLES; i++) begin
      act_x[i] = cheat_latched ? topLeftX_Cheat[i] : topLeftX_Original[i];
      act_y[i] = cheat_latched ? topLeftY_Cheat[i] : topLeftY_Original[i];
    end
  end

  logic [NUM_HOLES-1:0] hit;
  logic [10:0]          hit_ox [NUM_HOLES];
  logic [10:0]          hit_oy [NUM_HOLES];

  for (genvar g = 0; g < NUM_HOLES; g++) begin : g_hole
    wormhole_hit #(
      .OBJECT_WIDTH_X (OBJECT_WIDTH_X),
      .OBJECT_HEIGHT_Y(OBJECT_HEIGHT_Y)
    ) u_hit (
      .pixelX  (pixelX),
      .pixelY  (pixelY),
      .topLeftX(act_x[g]),
      .topLeftY(act_y[g]),
      .hit     (hit[g]),
      .offsetX (hit_ox[g]),
      .offsetY (hit_oy[g])
    );
  end

  // Lowest index wins: later holes only claim the pixel if nothing did yet.
  logic             win_hit;
  logic [IDX_W-1:0] win_idx;
  logic [10:0]      win_ox, win_oy;

  always_comb begin
    win_hit = 1'b0;
    win_idx = '0;
    win_ox  = '0;
    win_oy  = '0;
    for (int unsigned i = 0; i < NUM_HOLES; i++) begin
      if (hit[i] && !win_hit) begin
        win_hit = 1'b1;
        win_idx = IDX_W'(i);
        win_ox  = hit_ox[i];
        win_oy  = hit_oy[i];
      end
    end
  end

  wh_state_t state, state_nxt;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      drawingRequest <= 1'b0;
      RGBout         <= '0;
      offsetX        <= '0;
      offsetY        <= '0;
      holeIndex      <= '0;
    end else begin
      drawingRequest <= win_hit;
      RGBout         <= !win_hit             ? TRANSPARENT_ENCODING :
                        (state == COOLDOWN)  ? COOLDOWN_COLOR : OBJECT_COLOR;
      offsetX        <= win_ox;
      offsetY        <= win_oy;
      holeIndex      <= win_idx;
    end
  end

  logic [7:0]       cnt, cnt_nxt;
  logic             tv_nxt;
  coord_t           dx_nxt, dy_nxt;
  logic [IDX_W-1:0] partner;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state         <= OPEN;
      cnt           <= '0;
      teleportValid <= 1'b0;
      destX         <= '0;
      destY         <= '0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      teleportValid <= tv_nxt;
      destX         <= dx_nxt;
      destY         <= dy_nxt;
    end
  end

  // Destination uses act_x/act_y, i.e. the cheat latch value before any
  // update happening on this same edge.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    tv_nxt    = 1'b0;
    dx_nxt    = destX;
    dy_nxt    = destY;
    partner   = teleportHole ^ IDX_W'(1);
    case (state)
      OPEN: begin
        if (teleportReq) begin
          tv_nxt    = 1'b1;
          dx_nxt    = act_x[partner];
          dy_nxt    = act_y[partner];
          cnt_nxt   = 8'(COOLDOWN_FRAMES);
          state_nxt = COOLDOWN;
        end
      end
      COOLDOWN: begin
        if (startOfFrame) begin
          cnt_nxt = cnt - 8'd1;
          if (cnt == 8'd1)
            state_nxt = OPEN;
        end
      end
      default: state_nxt = OPEN;
    endcase
  end

  assign cooldownActive = (state == COOLDOWN);

endmodule
